maze_builder: RTL and testbench

//  Generates a random tank-arena maze and streams it, one 32-bit word per cycle,

---
 rtl/maze_builder_pkg.sv | 31 +++
 rtl/lfsr16.sv | 43 ++++
 rtl/maze_builder.sv | 194 +++++++++++++++++++
 tb/tb_maze_builder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_builder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_builder_pkg
// Description : Shared geometry constants and FSM state type for the tank
//               arena maze generator.
//               Maze = 160x120 wall bitmap, stored as 5 x 32-bit words per
//               row, tiled as 20x15 coarse cells of 8x8 bits.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_builder_pkg;

    localparam int MAZE_COLS     = 160;
    localparam int MAZE_ROWS     = 120;
    localparam int WORDS_PER_ROW = 5;
    localparam int CELL_BITS     = 8;
    localparam int COARSE_COLS   = 20;
    localparam int COARSE_ROWS   = 15;

    // An all-zero Galois LFSR is stuck forever, so a zero seed falls back here.
    localparam logic [15:0] LFSR_FALLBACK_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROLL  = 3'd1,
        EMIT  = 3'd2,
        SPAWN = 3'd3,
        DONE  = 3'd4
    } maze_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Galois LFSR, taps 16,14,13,11 (right shift, mask
//               16'hB400). Reusable random source for maze and game logic.
// Ports       : CLK   in  1   clock
//               RESET in  1   synchronous active-low reset (loads seed)
//               load  in  1   reload seed
//               seed  in  16  seed value (0 replaced by 16'hACE1)
//               step  in  1   advance one state this cycle
//               q     out 16  current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import maze_builder_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic [15:0] w_seed;
    logic [15:0] w_next;

    assign w_seed = (seed == 16'h0000) ? LFSR_FALLBACK_SEED : seed;
    assign w_next = {1'b0, r_q[15:1]} ^ (r_q[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge CLK) begin
        if (!RESET || load) begin
            r_q <= w_seed;
        end else if (step) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/maze_builder.sv
`default_nettype none
// ============================================================================
// Module      : maze_builder
// Description : Builds a random tank-arena maze one coarse row at a time
//               (20 cycles rolling walls, 40 cycles writing 8 rows x 5 words)
//               and streams it into the 600-word maze wall store. Then picks
//               both tanks' spawn X positions and raises maze_ready.
// Ports       : CLK        in  1   system clock
//               RESET      in  1   synchronous active-low reset
//               start      in  1   pulse: (re)build a maze
//               maze_we    out 1   store write strobe
//               maze_waddr out 10  word address 0..599
//               maze_wdata out 32  wall bits, bit 31 = leftmost column
//               maze_ready out 1   complete maze in store
//               spawn_pos  out 20  [19:10] tank2 X px, [9:0] tank1 X px
//               busy       out 1   build in progress
// Revision    : 1.0 - initial release
// ============================================================================
module maze_builder
    import maze_builder_pkg::*;
#(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [4:0]  H_THRESH = 5'd6,
    parameter logic [4:0]  V_THRESH = 5'd6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    output logic        maze_we,
    output logic [9:0]  maze_waddr,
    output logic [31:0] maze_wdata,
    output logic        maze_ready,
    output logic [19:0] spawn_pos,
    output logic        busy
);

    maze_state_t             r_state;
    maze_state_t             w_next_state;
    logic [3:0]              r_crow;
    logic [4:0]              r_cell;
    logic [2:0]              r_sub;
    logic [2:0]              r_word;
    logic [9:0]              r_addr;
    logic [COARSE_COLS-1:0]  r_hwall;
    logic [COARSE_COLS-1:0]  r_vwall;
    logic                    r_we;
    logic [9:0]              r_waddr;
    logic [31:0]             r_wdata;
    logic                    r_ready;
    logic                    r_busy;
    logic [19:0]             r_spawn;

    logic [15:0]             w_lfsr;
    logic                    w_lfsr_step;
    logic                    w_last_cell;
    logic                    w_last_word;
    logic [6:0]              w_row;
    logic [31:0]             w_word_bits;

    // Wall bits of one 32-column word. Coarse-cell walls only occupy the
    // last bit row/column of each 8x8 cell, so cell interiors stay open.
    function automatic logic [31:0] wall_word(
        input logic [6:0]             row,
        input logic [2:0]             word,
        input logic [COARSE_COLS-1:0] hwall,
        input logic [COARSE_COLS-1:0] vwall
    );
        logic [31:0] bits;
        logic [7:0]  col;
        logic        border_row;
        bits       = '0;
        border_row = (row == 7'd0) || (row == 7'(MAZE_ROWS - 1));
        for (int b = 0; b < 32; b++) begin
            col     = {word, 5'b00000} + 8'(31 - b);
            bits[b] = border_row
                   || (col == 8'd0)
                   || (col == 8'(MAZE_COLS - 1))
                   || ((row[2:0] == 3'd7) && hwall[col[7:3]])
                   || ((col[2:0] == 3'd7) && vwall[col[7:3]]);
        end
        return bits;
    endfunction

    lfsr16 u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (1'b0),
        .seed  (SEED),
        .step  (w_lfsr_step),
        .q     (w_lfsr)
    );

    // Free-running in IDLE/DONE gathers entropy from start timing.
    assign w_lfsr_step = (r_state == IDLE) || (r_state == DONE) || (r_state == ROLL);
    assign w_last_cell = (r_cell == 5'(COARSE_COLS - 1));
    assign w_last_word = (r_sub == 3'(CELL_BITS - 1)) && (r_word == 3'(WORDS_PER_ROW - 1));
    assign w_row       = {r_crow, r_sub};
    assign w_word_bits = wall_word(w_row, r_word, r_hwall, r_vwall);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: w_next_state = r_state;
            ROLL:       if (w_last_cell) w_next_state = EMIT;
            EMIT:       if (w_last_word) w_next_state = (r_crow == 4'(COARSE_ROWS - 1)) ? SPAWN : ROLL;
            SPAWN:      w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
        // A start always restarts the build, even mid-emit or on the final word.
        if (start) w_next_state = ROLL;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_crow  <= '0;
            r_cell  <= '0;
            r_sub   <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_hwall <= '0;
            r_vwall <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_spawn <= '0;
        end else begin
            r_we <= 1'b0;
            if (start) begin
                // Aborting: the in-flight word is dropped and the store is
                // rewritten from address 0.
                r_crow  <= '0;
                r_cell  <= '0;
                r_sub   <= '0;
                r_word  <= '0;
                r_addr  <= '0;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ROLL: begin
                        r_hwall[r_cell] <= ({1'b0, w_lfsr[3:0]} < H_THRESH);
                        r_vwall[r_cell] <= ({1'b0, w_lfsr[7:4]} < V_THRESH);
                        r_cell          <= w_last_cell ? 5'd0 : r_cell + 5'd1;
                    end
                    EMIT: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= w_word_bits;
                        r_addr  <= r_addr + 10'd1;
                        if (r_word == 3'(WORDS_PER_ROW - 1)) begin
                            r_word <= 3'd0;
                            r_sub  <= (r_sub == 3'(CELL_BITS - 1)) ? 3'd0 : r_sub + 3'd1;
                        end else begin
                            r_word <= r_word + 3'd1;
                        end
                        if (w_last_word && (r_crow != 4'(COARSE_ROWS - 1))) begin
                            r_crow <= r_crow + 4'd1;
                        end
                    end
                    SPAWN: begin
                        // Centre of a coarse cell: col*32 + 16 px.
                        r_spawn <= {5'(5'd12 + {2'b00, w_lfsr[5:3]}), 5'b10000,
                                    2'b00, w_lfsr[2:0], 5'b10000};
                    end
                    DONE: begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign maze_we    = r_we;
    assign maze_waddr = r_waddr;
    assign maze_wdata = r_wdata;
    assign maze_ready = r_ready;
    assign spawn_pos  = r_spawn;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_maze_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_builder
// Description : Self-checking bench for maze_builder. Three instances share
//               clock/reset/start: defaults, no walls (0/0), all walls (16/16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_builder;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;

    logic        d_we,  z_we,  f_we;
    logic [9:0]  d_waddr, z_waddr, f_waddr;
    logic [31:0] d_wdata, z_wdata, f_wdata;
    logic        d_ready, z_ready, f_ready;
    logic [19:0] d_spawn, z_spawn, f_spawn;
    logic        d_busy, z_busy, f_busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rst_edge = 0;
    int wr_cnt = 0;
    int exp_addr = 0;
    int order_err = 0;
    int first_cyc = 0;
    int ready_rise = 0;
    int busy_fall = 0;
    logic ready_prev = 1'b0;
    logic busy_prev = 1'b0;

    logic [31:0] mem_d [600];
    logic [31:0] mem_z [600];
    logic [31:0] mem_f [600];

    bit hw [15][20];
    bit vw [15][20];

    always #10 CLK = ~CLK;

    maze_builder u_dut (
        .CLK(CLK), .RESET(RESET), .start(start),
        .maze_we(d_we), .maze_waddr(d_waddr), .maze_wdata(d_wdata),
        .maze_ready(d_ready), .spawn_pos(d_spawn), .busy(d_busy)
    );

    maze_builder #(.H_THRESH(5'd0), .V_THRESH(5'd0)) u_zero (
        .CLK(CLK), .RESET(RESET), .start(start),
        .maze_we(z_we), .maze_waddr(z_waddr), .maze_wdata(z_wdata),
        .maze_ready(z_ready), .spawn_pos(z_spawn), .busy(z_busy)
    );

    maze_builder #(.H_THRESH(5'd16), .V_THRESH(5'd16)) u_full (
        .CLK(CLK), .RESET(RESET), .start(start),
        .maze_we(f_we), .maze_waddr(f_waddr), .maze_wdata(f_wdata),
        .maze_ready(f_ready), .spawn_pos(f_spawn), .busy(f_busy)
    );

    // Write monitor, sampled 1 time unit after each rising edge.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (!RESET) rst_edge = cyc;
        #1;
        if (d_we === 1'b1) begin
            if (wr_cnt == 0) first_cyc = cyc;
            if (d_waddr !== 10'(exp_addr)) order_err++;
            if (d_waddr < 10'd600) mem_d[d_waddr] = d_wdata;
            exp_addr++;
            wr_cnt++;
        end
        if (z_we === 1'b1 && z_waddr < 10'd600) mem_z[z_waddr] = z_wdata;
        if (f_we === 1'b1 && f_waddr < 10'd600) mem_f[f_waddr] = f_wdata;
        if (d_ready === 1'b1 && ready_prev === 1'b0 && ready_rise == 0) ready_rise = cyc;
        if (d_busy === 1'b0 && busy_prev === 1'b1 && busy_fall == 0) busy_fall = cyc;
        ready_prev = d_ready;
        busy_prev  = d_busy;
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        logic [15:0] n;
        n = q >> 1;
        if (q[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [31:0] model_word(input int a);
        int row, w, cr, c;
        logic [31:0] v;
        row = a / 5;
        w   = a % 5;
        cr  = row / 8;
        v   = '0;
        for (int k = 0; k < 32; k++) begin
            c = w * 32 + k;
            v[31 - k] = (row == 0) || (row == 119) || (c == 0) || (c == 159)
                     || ((row % 8 == 7) && hw[cr][c / 8])
                     || ((c % 8 == 7) && vw[cr][c / 8]);
        end
        return v;
    endfunction

    // Called at a negedge: pulses start across the next rising edge.
    task automatic kick(output int edge_no);
        wr_cnt     = 0;
        exp_addr   = 0;
        order_err  = 0;
        first_cyc  = 0;
        ready_rise = 0;
        busy_fall  = 0;
        start      = 1'b1;
        edge_no    = cyc + 1;
        @(negedge CLK);
        start      = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (d_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (d_we !== 1'b0)      begin errors++; $display("FAIL reset_we got %b want 0", d_we); end
        checks++; if (d_waddr !== 10'd0)  begin errors++; $display("FAIL reset_waddr got %0d want 0", d_waddr); end
        checks++; if (d_wdata !== 32'd0)  begin errors++; $display("FAIL reset_wdata got %h want 0", d_wdata); end
        checks++; if (d_ready !== 1'b0)   begin errors++; $display("FAIL reset_ready got %b want 0", d_ready); end
        checks++; if (d_spawn !== 20'd0)  begin errors++; $display("FAIL reset_spawn got %h want 0", d_spawn); end
        checks++; if (d_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", d_busy); end
        RESET  = 1'b1;
        wr_cnt = 0;
        repeat (30) @(negedge CLK);
        checks++; if (wr_cnt !== 0)       begin errors++; $display("FAIL idle_no_write got %0d writes want 0", wr_cnt); end
        checks++; if (d_busy !== 1'b0)    begin errors++; $display("FAIL idle_busy got %b want 0", d_busy); end
    endtask

    task automatic test_build();
        int s, n;
        bit ok;
        logic [15:0] q;
        logic [19:0] exp_spawn;
        logic [31:0] exp;
        @(negedge CLK);
        kick(s);
        wait_ready(1200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL build_timeout got ready=%b want 1", d_ready); end
        checks++; if (first_cyc - s !== 21) begin errors++; $display("FAIL build_first_write got %0d want 21", first_cyc - s); end
        checks++; if (wr_cnt !== 600) begin errors++; $display("FAIL build_write_count got %0d want 600", wr_cnt); end
        checks++; if (order_err !== 0) begin errors++; $display("FAIL build_addr_order got %0d bad addrs want 0", order_err); end
        checks++; if (ready_rise - s !== 902) begin errors++; $display("FAIL build_ready_latency got %0d want 902", ready_rise - s); end
        checks++; if (busy_fall !== ready_rise) begin errors++; $display("FAIL build_busy_fall got %0d want %0d", busy_fall, ready_rise); end

        // Reference LFSR: loaded at the last reset edge, one step per idle
        // edge up to and including the start edge, then 20 per coarse row.
        n = s - rst_edge;
        q = 16'hACE1;
        repeat (n) q = lfsr_next(q);
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 20; i++) begin
                hw[k][i] = (q[3:0] < 4'd6);
                vw[k][i] = (q[7:4] < 4'd6);
                q = lfsr_next(q);
            end
        end
        exp_spawn[9:0]   = 10'(int'(q[2:0]) * 32 + 16);
        exp_spawn[19:10] = 10'((12 + int'(q[5:3])) * 32 + 16);
        checks++; if (d_spawn !== exp_spawn) begin errors++; $display("FAIL build_spawn got %h want %h", d_spawn, exp_spawn); end
        for (int a = 0; a < 600; a++) begin
            exp = model_word(a);
            checks++; if (mem_d[a] !== exp) begin errors++; $display("FAIL build_word%0d got %h want %h", a, mem_d[a], exp); end
        end

        checks++; if (mem_z[0]   !== 32'hFFFFFFFF) begin errors++; $display("FAIL nowall_word0 got %h want FFFFFFFF", mem_z[0]); end
        checks++; if (mem_z[5]   !== 32'h80000000) begin errors++; $display("FAIL nowall_word5 got %h want 80000000", mem_z[5]); end
        checks++; if (mem_z[9]   !== 32'h00000001) begin errors++; $display("FAIL nowall_word9 got %h want 00000001", mem_z[9]); end
        checks++; if (mem_z[595] !== 32'hFFFFFFFF) begin errors++; $display("FAIL nowall_word595 got %h want FFFFFFFF", mem_z[595]); end
        checks++; if (mem_f[35]  !== 32'hFFFFFFFF) begin errors++; $display("FAIL allwall_word35 got %h want FFFFFFFF", mem_f[35]); end
        checks++; if (mem_f[40]  !== 32'h81010101) begin errors++; $display("FAIL allwall_word40 got %h want 81010101", mem_f[40]); end
    endtask

    task automatic test_restart();
        int s0, s, guard;
        bit ok;
        @(negedge CLK);
        kick(s0);
        guard = 0;
        while (wr_cnt < 300 && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        checks++; if (wr_cnt !== 300) begin errors++; $display("FAIL restart_reach300 got %0d want 300", wr_cnt); end
        kick(s);
        wait_ready(1200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL restart_timeout got ready=%b want 1", d_ready); end
        // 20 quiet roll cycles, then address 0 on the 21st edge after start.
        checks++; if (first_cyc - s !== 21) begin errors++; $display("FAIL restart_first_write got %0d want 21", first_cyc - s); end
        checks++; if (wr_cnt !== 600) begin errors++; $display("FAIL restart_write_count got %0d want 600", wr_cnt); end
        checks++; if (order_err !== 0) begin errors++; $display("FAIL restart_addr_order got %0d bad addrs want 0", order_err); end
        checks++; if (ready_rise - s !== 902) begin errors++; $display("FAIL restart_ready_latency got %0d want 902", ready_rise - s); end
    endtask

    task automatic test_back_to_back();
        int s, t1, t2, viol, col;
        bit ok;
        logic [31:0] wv;
        for (int b = 0; b < 10; b++) begin
            repeat ($urandom_range(0, 40)) @(negedge CLK);
            @(negedge CLK);
            kick(s);
            wait_ready(1200, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b%0d_timeout got ready=%b want 1", b, d_ready); end
            checks++; if (wr_cnt !== 600 || order_err !== 0) begin errors++; $display("FAIL b2b%0d_writes got %0d writes %0d bad want 600 0", b, wr_cnt, order_err); end
            t1 = int'(d_spawn[9:0]);
            t2 = int'(d_spawn[19:10]);
            checks++; if (!(t1 >= 16 && t1 <= 240 && (t1 - 16) % 32 == 0)) begin errors++; $display("FAIL b2b%0d_tank1 got %0d want 16+32k<=240", b, t1); end
            checks++; if (!(t2 >= 400 && t2 <= 624 && (t2 - 16) % 32 == 0)) begin errors++; $display("FAIL b2b%0d_tank2 got %0d want 400+32k<=624", b, t2); end
            viol = 0;
            for (int r = 1; r < 119; r++) begin
                if (r % 8 != 7) begin
                    for (int j = 0; j < 4; j++) begin
                        col = ((j < 2) ? t1 : t2) / 4 + (j % 2);
                        wv  = mem_d[r * 5 + col / 32];
                        if (wv[31 - col % 32] !== 1'b0) viol++;
                    end
                end
            end
            checks++; if (viol !== 0) begin errors++; $display("FAIL b2b%0d_spawn_centre got %0d wall bits want 0", b, viol); end
        end
    endtask

    initial begin
        test_reset();
        test_build();
        test_restart();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
